// File: rtl/us_pkg.sv
// Shared types and constants for the ultrasonic burst sequencer.
package us_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } us_state_t;

    localparam int DIV_DEF  = 1250;
    localparam int DEAD_DEF = 25;

    function automatic int phase_w(input int div);
        return $clog2(div);
    endfunction

    localparam int PHASE_W = phase_w(DIV_DEF);

endpackage

// File: rtl/us_burst_ctrl_if.sv
// Control/status and transducer drive bundle between the measurement logic and the burst sequencer.
interface us_burst_ctrl_if;

    logic        start;
    logic        abort;
    logic [7:0]  burst_len;
    logic [15:0] gap_len;
    logic [7:0]  num_bursts;
    logic        trans;
    logic        trans_n;
    logic        burst_on;
    logic        busy;
    logic        done;

    modport master (
        output start, abort, burst_len, gap_len, num_bursts,
        input  trans, trans_n, burst_on, busy, done
    );

    modport slave (
        input  start, abort, burst_len, gap_len, num_bursts,
        output trans, trans_n, burst_on, busy, done
    );

endinterface

// File: rtl/us_carrier_div.sv
// Carrier phase counter: counts 0..DIV-1 and strobes wrap on the last phase of each period.
module us_carrier_div
    import us_pkg::*;
#(
    parameter int DIV = DIV_DEF,
    parameter int PW  = PHASE_W
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clr,
    input  logic          en,
    output logic [PW-1:0] phase,
    output logic          wrap
);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    assign wrap = en && (phase == LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/us_burst_ctrl.sv
// Ultrasonic tone-burst sequencer with complementary H-bridge drive.
// Optional dead-time insertion on every drive edge is enabled by defining DEADTIME_EN.
module us_burst_ctrl
    import us_pkg::*;
#(
    parameter int DIV  = DIV_DEF,
    parameter int DEAD = DEAD_DEF
) (
    input  logic           CLK,
    input  logic           RST_N,
    us_burst_ctrl_if.slave bus
);

    localparam int PW = phase_w(DIV);

`ifdef DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    localparam int            LEAD   = DT_EN ? DEAD : 0;
    localparam logic [PW-1:0] LEAD_P = PW'(LEAD);
    localparam logic [PW-1:0] HALF_P = PW'(DIV / 2);
    localparam logic [PW-1:0] WIN_P  = PW'(DIV / 2 - LEAD);

    // Window test via modular offset: phases before the window wrap to large values.
    function automatic logic drive_p(input logic [PW-1:0] ph);
        logic [PW-1:0] rel;
        rel = ph - LEAD_P;
        return rel < WIN_P;
    endfunction

    function automatic logic drive_n(input logic [PW-1:0] ph);
        logic [PW-1:0] rel;
        rel = ph - HALF_P - LEAD_P;
        return rel < WIN_P;
    endfunction

    us_state_t     state;
    logic [7:0]    per_cnt;
    logic [7:0]    bst_cnt;
    logic [15:0]   gap_cnt;
    logic [7:0]    bl_q;
    logic [15:0]   gl_q;
    logic [7:0]    nb_q;

    logic          trans_r;
    logic          trans_n_r;
    logic          burst_on_r;
    logic          busy_r;
    logic          done_r;

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nx;
    logic          wrap;
    logic          clr;
    logic          en;
    logic          accept;
    logic          burst_end;
    logic          last_burst;
    logic          gap_end;
    logic          p_drv;
    logic          n_drv;

    us_carrier_div #(
        .DIV (DIV),
        .PW  (PW)
    ) u_div (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (clr),
        .en    (en),
        .phase (phase),
        .wrap  (wrap)
    );

    always_comb begin
        clr        = bus.abort || (state == IDLE);
        en         = (state != IDLE);
        accept     = (state == IDLE) && bus.start && !bus.abort && (bus.burst_len != 8'd0);
        burst_end  = (state == BURST) && wrap && (per_cnt == bl_q - 8'd1);
        last_burst = (bst_cnt == nb_q - 8'd1);
        gap_end    = (state == GAP) && wrap && (gap_cnt == gl_q - 16'd1);
        // Outputs are registered, so decode the phase the counter is about to take.
        phase_nx   = (clr || wrap) ? '0 : phase + PW'(1);
        p_drv      = drive_p(phase_nx);
        n_drv      = drive_n(phase_nx);
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            bl_q <= bus.burst_len;
            gl_q <= bus.gap_len;
            nb_q <= (bus.num_bursts == 8'd0) ? 8'd1 : bus.num_bursts;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            per_cnt    <= '0;
            bst_cnt    <= '0;
            gap_cnt    <= '0;
            trans_r    <= 1'b0;
            trans_n_r  <= 1'b0;
            burst_on_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.abort) begin
                state      <= IDLE;
                per_cnt    <= '0;
                bst_cnt    <= '0;
                gap_cnt    <= '0;
                trans_r    <= 1'b0;
                trans_n_r  <= 1'b0;
                burst_on_r <= 1'b0;
                busy_r     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state      <= BURST;
                            per_cnt    <= '0;
                            bst_cnt    <= '0;
                            gap_cnt    <= '0;
                            trans_r    <= p_drv;
                            trans_n_r  <= n_drv;
                            burst_on_r <= 1'b1;
                            busy_r     <= 1'b1;
                        end
                    end
                    BURST: begin
                        if (burst_end) begin
                            per_cnt <= '0;
                            if (last_burst) begin
                                state      <= IDLE;
                                trans_r    <= 1'b0;
                                trans_n_r  <= 1'b0;
                                burst_on_r <= 1'b0;
                                busy_r     <= 1'b0;
                                done_r     <= 1'b1;
                            end else if (gl_q == 16'd0) begin
                                bst_cnt   <= bst_cnt + 8'd1;
                                trans_r   <= p_drv;
                                trans_n_r <= n_drv;
                            end else begin
                                state      <= GAP;
                                bst_cnt    <= bst_cnt + 8'd1;
                                gap_cnt    <= '0;
                                trans_r    <= 1'b0;
                                trans_n_r  <= 1'b0;
                                burst_on_r <= 1'b0;
                            end
                        end else begin
                            if (wrap) begin
                                per_cnt <= per_cnt + 8'd1;
                            end
                            trans_r   <= p_drv;
                            trans_n_r <= n_drv;
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            state      <= BURST;
                            gap_cnt    <= '0;
                            trans_r    <= p_drv;
                            trans_n_r  <= n_drv;
                            burst_on_r <= 1'b1;
                        end else if (wrap) begin
                            gap_cnt <= gap_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.trans    = trans_r;
    assign bus.trans_n  = trans_n_r;
    assign bus.burst_on = burst_on_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_us_burst_ctrl.sv
// Directed bench for us_burst_ctrl at DIV=8, DEAD=1; expectations follow DEADTIME_EN when defined.
module tb_us_burst_ctrl;

    localparam int DIV = 8;
`ifdef DEADTIME_EN
    localparam int LEAD = 1;
    localparam bit DT   = 1'b1;
`else
    localparam int LEAD = 0;
    localparam bit DT   = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } spot_t;

    typedef struct {
        int bl;
        int gl;
        int nb;
        int done_at;
    } cfg_t;

    logic CLK;
    logic RST_N;
    int   total;
    int   bad;

    us_burst_ctrl_if bus ();

    us_burst_ctrl #(
        .DIV  (DIV),
        .DEAD (1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    spot_t spots[11];
    cfg_t  cfgs[5];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {bus.trans, bus.trans_n, bus.burst_on, bus.busy, bus.done};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Expected {trans, trans_n, burst_on, busy, done} for cycle c after the accepting edge.
    function automatic logic [4:0] model(input int c, input int bl, input int gl, input int nbe);
        int o;
        int tot;
        int k;
        int ph;
        logic tp;
        logic tn;
        o   = c - 1;
        tot = nbe * bl * DIV + (nbe - 1) * gl * DIV;
        if (c < 1) return 5'b00000;
        if (o >= tot) return (o == tot) ? 5'b00001 : 5'b00000;
        k = o % ((bl + gl) * DIV);
        if (k >= bl * DIV) return 5'b00010;
        ph = k % DIV;
        tp = (ph >= LEAD) && (ph < DIV / 2);
        tn = (ph >= DIV / 2 + LEAD);
        return {tp, tn, 1'b1, 1'b1, 1'b0};
    endfunction

    task automatic launch(input int bl, input int gl, input int nb);
        bus.burst_len  = 8'(bl);
        bus.gap_len    = 16'(gl);
        bus.num_bursts = 8'(nb);
        bus.start      = 1'b1;
        step();
        bus.start      = 1'b0;
    endtask

    task automatic watch(input int c0, input int c1, input int off, input int bl, input int gl,
                         input int nbe, input bit spot, input bit poke, output int done_at);
        done_at = -1;
        for (int c = c0; c <= c1; c++) begin
            logic [4:0] got;
            logic [4:0] exp;
            if (poke && c == 30) begin
                bus.start      = 1'b1;
                bus.burst_len  = 8'd1;
                bus.gap_len    = 16'd0;
                bus.num_bursts = 8'd5;
            end
            if (poke && c == 31) bus.start = 1'b0;
            got = outs();
            exp = model(c - off, bl, gl, nbe);
            chk($sformatf("seq c=%0d bl=%0d gl=%0d nb=%0d", c, bl, gl, nbe), int'(got), int'(exp));
            chk($sformatf("overlap c=%0d", c), int'(got[4] & got[3]), 0);
            if (spot) begin
                for (int i = 0; i < 11; i++) begin
                    if (spots[i].cyc == c) chk($sformatf("spot c=%0d", c), int'(got), int'(spots[i].vec));
                end
            end
            if (got[0] && done_at < 0) done_at = c;
            step();
        end
    endtask

    initial begin
        int d;
        total = 0;
        bad   = 0;

        spots[0]  = '{1,  DT ? 5'b00110 : 5'b10110};
        spots[1]  = '{4,  5'b10110};
        spots[2]  = '{5,  DT ? 5'b00110 : 5'b01110};
        spots[3]  = '{8,  5'b01110};
        spots[4]  = '{12, 5'b10110};
        spots[5]  = '{25, 5'b00010};
        spots[6]  = '{40, 5'b00010};
        spots[7]  = '{41, DT ? 5'b00110 : 5'b10110};
        spots[8]  = '{64, 5'b01110};
        spots[9]  = '{65, 5'b00001};
        spots[10] = '{66, 5'b00000};

        cfgs[0] = '{3, 2, 2, 65};
        cfgs[1] = '{3, 0, 2, 49};
        cfgs[2] = '{1, 1, 3, 41};
        cfgs[3] = '{2, 5, 0, 17};
        cfgs[4] = '{1, 0, 1, 9};

        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.burst_len  = 8'd0;
        bus.gap_len    = 16'd0;
        bus.num_bursts = 8'd0;
        RST_N          = 1'b0;
        step();
        step();
        chk("reset outputs", int'(outs()), 0);
        RST_N = 1'b1;
        step();
        chk("idle after reset", int'(outs()), 0);

        // Reference sequence, with a start and config change injected mid-sequence.
        launch(3, 2, 2);
        watch(1, 67, 0, 3, 2, 2, 1'b1, 1'b1, d);
        chk("done cycle ref", d, 65);

        for (int i = 0; i < 5; i++) begin
            int nbe;
            nbe = (cfgs[i].nb == 0) ? 1 : cfgs[i].nb;
            launch(cfgs[i].bl, cfgs[i].gl, cfgs[i].nb);
            watch(1, cfgs[i].done_at + 2, 0, cfgs[i].bl, cfgs[i].gl, nbe, 1'b0, 1'b0, d);
            chk($sformatf("done cycle cfg%0d", i), d, cfgs[i].done_at);
        end

        // Abort in cycle 10, then restart in cycle 20.
        launch(3, 2, 2);
        watch(1, 9, 0, 3, 2, 2, 1'b0, 1'b0, d);
        chk("abort c=10 pre", int'(outs()), int'(model(10, 3, 2, 2)));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        for (int c = 11; c <= 20; c++) begin
            chk($sformatf("aborted c=%0d", c), int'(outs()), 0);
            if (c < 20) step();
        end
        launch(3, 2, 2);
        chk("restart busy c=21", int'(bus.busy), 1);
        watch(21, 87, 20, 3, 2, 2, 1'b0, 1'b0, d);
        chk("done cycle restart", d, 85);

        // New start accepted in the done cycle.
        launch(1, 0, 1);
        watch(1, 8, 0, 1, 0, 1, 1'b0, 1'b0, d);
        chk("done cycle c=9", int'(outs()), 1);
        launch(1, 0, 1);
        watch(10, 19, 9, 1, 0, 1, 1'b0, 1'b0, d);
        chk("done after back-to-back", d, 18);

        // start and abort together: abort wins.
        bus.burst_len  = 8'd3;
        bus.gap_len    = 16'd2;
        bus.num_bursts = 8'd2;
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("start+abort c=%0d", c), int'(outs()), 0);
            step();
        end

        // burst_len=0 is ignored.
        launch(0, 2, 2);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("zero burst_len c=%0d", c), int'(outs()), 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/us_burst_ctrl.md
# us_burst_ctrl

Sequencer for the 40 kHz ultrasonic transmitter. On a start request it drives the transducer with a programmed number of tone bursts, each a fixed number of carrier periods, separated by silent gaps. It provides complementary H-bridge drive outputs, busy/done status, and an abort path. It sits between the measurement control logic and the transducer driver pins.

## Interface
- DIV, 1250: carrier period in CLK cycles (40 kHz at 50 MHz); even, ≥ 4
- DEAD, 25: dead-time cycles per half-period edge; used only with DEADTIME_EN; 0 < DEAD < DIV/2
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- start  in  1  sequence request; sampled in IDLE only
- abort  in  1  immediate termination; valid in any state
- burst_len  in  8  carrier periods per burst
- gap_len  in  16  carrier periods of silence between bursts
- num_bursts  in  8  bursts per sequence; 0 treated as 1
- trans  out  1  transducer drive, positive leg
- trans_n  out  1  transducer drive, complementary leg
- burst_on  out  1  high while in BURST
- busy  out  1  high from first BURST cycle until the sequence ends
- done  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, BURST, GAP. All outputs are registered.
- Reset (RST_N low) forces IDLE; trans, trans_n, burst_on, busy and done are all 0. The phase, period and burst counters clear to 0.
- IDLE: if start=1, abort=0 and burst_len≠0:
  - latch burst_len, gap_len and num_bursts;
  - go to BURST with phase=0.
- start with burst_len=0 is ignored: no busy, no done.
- Phase counter: width clog2(DIV). Counts 0..DIV-1 and wraps; the wrap strobe marks the end of a carrier period.
- BURST:
  - trans=1 for phase in [0, DIV/2); trans_n=1 for phase in [DIV/2, DIV).
  - The period counter increments on each wrap.
  - After the latched burst_len periods, exit BURST:
    - last burst → IDLE with a done pulse;
    - otherwise, gap_len=0 → BURST directly, with the phase continuing from 0;
    - otherwise → GAP.
- GAP: trans and trans_n are 0. Counts gap_len×DIV cycles, then goes to BURST.
- The final burst is never followed by a gap.
- abort=1 in any state: IDLE on the next edge, all outputs 0, no done pulse. If abort and start are asserted together in IDLE, abort wins.
- start while busy is ignored. Changes to the config inputs while busy have no effect until the next accepted start.
- trans and trans_n are never high in the same cycle.

## Timing
- start sampled at edge t → busy=1, burst_on=1 and trans=1 from cycle t+1.
- Burst duration: burst_len×DIV cycles. Gap duration: gap_len×DIV cycles.
- Total busy time: num_bursts×burst_len×DIV + (num_bursts−1)×gap_len×DIV cycles.
- On normal completion, done=1 for the single cycle after the last BURST cycle. busy falls in that same cycle.
- A new start is accepted in the done cycle, since the block is already in IDLE.

## Configuration
- DEADTIME_EN defined:
  - trans=1 for phase in [DEAD, DIV/2);
  - trans_n=1 for phase in [DIV/2+DEAD, DIV);
  - both legs are low for DEAD cycles after every transition;
  - the first trans rise is at cycle t+1+DEAD.
- DEADTIME_EN undefined: plain 50% complementary drive as described in Operation; DEAD is unused.

## Structure
- Package us_pkg:
  - state enum type (IDLE, BURST, GAP);
  - default DIV and DEAD constants;
  - phase-width constant derived from DIV.
- Sub-module us_carrier_div:
  - phase counter with synchronous clear and enable;
  - outputs phase and a wrap strobe.
- The FSM, period/burst/gap counters and output registers live in us_burst_ctrl.

## Test plan
- DIV=8, burst_len=3, gap_len=2, num_bursts=2, start at cycle 0 (DEADTIME_EN off). Required:
  - trans high in cycles 1–4, 9–12, 17–20, 41–44, 49–52, 57–60;
  - trans_n high in cycles 5–8, 13–16, 21–24, 45–48, 53–56, 61–64;
  - outputs low in cycles 25–40;
  - done=1 only in cycle 65; busy=1 in cycles 1–64.
- Same configuration with gap_len=0. Required: bursts back-to-back in cycles 1–48; done in cycle 49.
- abort asserted in cycle 10 of the first scenario. Required: all outputs 0 from cycle 11; no done pulse. A following start in cycle 20 begins a fresh sequence in cycle 21.
- start and abort asserted together in IDLE. Required: busy stays 0.
- burst_len=0 with start. Required: busy and done stay 0.
- DEADTIME_EN on, DIV=8, DEAD=1, burst_len=1. Required: trans high in cycles 2–4, trans_n high in cycles 6–8; never both high in any cycle.
